// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, radix-2 shift-add / restoring shift-subtract
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            regwrite
);
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] f3;
    logic [4:0] rd_q;
    logic [XLEN:0] hi, hi_n, msum, hs, sh;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] lo, lo_n, m, ma, mb, q, r, res;
    logic [2*XLEN-1:0] prod, prod_s;
    logic neg, a_neg, div0, accept, last, sa, sb, an, bn;
    assign accept   = state == IDLE && start;
    assign last     = state == CALC && cnt == CW'(XLEN - 1);
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign regwrite = done && rd_out != 5'd0;
    always_comb begin
        state_n = state == IDLE ? (start ? CALC : IDLE) : state == CALC ? (last ? DONE : CALC) : IDLE;
    end
    // operand signedness: MUL/MULH/MULHSU treat A as signed, MUL/MULH treat B as signed, DIV/REM both
    always_comb begin
        sa = funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11;
        sb = funct3[2] ? ~funct3[0] : ~funct3[1];
        an = sa & rs1_data[XLEN-1];
        bn = sb & rs2_data[XLEN-1];
        ma = an ? -rs1_data : rs1_data;
        mb = bn ? -rs2_data : rs2_data;
    end
    // hi holds the running product high half (mul) or partial remainder (div); lo the multiplier / quotient
    always_comb begin
        msum   = hi + {1'b0, m};
        hs     = lo[0] ? msum : hi;
        sh     = {hi[XLEN-1:0], lo[XLEN-1]};
        diff   = {1'b0, sh} - {2'b00, m};
        hi_n   = f3[2] ? (diff[XLEN+1] ? sh : diff[XLEN:0]) : {1'b0, hs[XLEN:1]};
        lo_n   = f3[2] ? {lo[XLEN-2:0], ~diff[XLEN+1]} : {hs[0], lo[XLEN-1:1]};
        prod   = {hi_n[XLEN-1:0], lo_n};
        prod_s = neg ? -prod : prod;
        q      = neg ? -lo_n : lo_n;
        r      = a_neg ? -hi_n[XLEN-1:0] : hi_n[XLEN-1:0];
        res    = f3[2] ? (f3[1] ? r : (div0 ? '1 : q))
                       : (f3[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            f3     <= '0;
            rd_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            neg    <= 1'b0;
            a_neg  <= 1'b0;
            div0   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                f3    <= funct3;
                rd_q  <= rd_in;
                cnt   <= '0;
                hi    <= '0;
                m     <= funct3[2] ? mb : ma;
                lo    <= funct3[2] ? ma : mb;
                neg   <= an ^ bn;
                a_neg <= an;
                div0  <= rs2_data == '0;
            end else if (state == CALC) begin
                hi  <= hi_n;
                lo  <= lo_n;
                cnt <= cnt + CW'(1);
                if (last) begin
                    result <= res;
                    rd_out <= rd_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results
module tb_muldiv_unit;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic [4:0] rd_in = '0;
    logic busy, done, regwrite;
    logic [31:0] result;
    logic [4:0] rd_out;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .regwrite(regwrite)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
        int n;
        @(negedge clk);
        funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = ~f; rs1_data = ~a; rs2_data = b + 32'd3; rd_in = ~rd;
        check({tag, "/busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/latency"}, n, 32);
        check({tag, "/result"}, result, exp);
        check({tag, "/rd"}, 32'(rd_out), 32'(rd));
        check({tag, "/regwrite"}, 32'(regwrite), 32'(rd != 5'd0));
        @(posedge clk);
        #1;
        check({tag, "/idle"}, {30'd0, busy, done}, 32'd0);
    endtask
    initial begin
        int n, seen;
        repeat (2) @(posedge clk);
        #1;
        check("reset/outs", {busy, done, regwrite, rd_out}, 32'd0);
        check("reset/result", result, 32'd0);
        reset = 1'b0;
        run("mul",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        run("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE);
        run("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000);
        run("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);
        run("mulhu2",   3'b011, 32'h00010000, 32'h00010000, 5'd9,  32'h00000001);
        run("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000);
        run("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000);
        run("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD);
        run("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF);
        run("divu0",    3'b101, 32'h1234,     32'd0,        5'd14, 32'hFFFFFFFF);
        run("remu0",    3'b111, 32'h1234,     32'd0,        5'd15, 32'h00001234);
        run("divu",     3'b101, 32'd100,      32'd7,        5'd31, 32'd14);
        run("div0_neg", 3'b100, 32'hFFFFFFFB, 32'd0,        5'd0,  32'hFFFFFFFF);
        run("rem0_neg", 3'b110, 32'hFFFFFFFB, 32'd0,        5'd1,  32'hFFFFFFFB);
        repeat (5) @(posedge clk);
        #1;
        check("hold/result", result, 32'hFFFFFFFB);
        // abort mid-calculation
        @(negedge clk);
        funct3 = 3'b100; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/result", result, 32'd0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || regwrite) seen = 1;
        end
        check("abort/nodone", seen, 0);
        // reset and start together
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start/busy", 32'(busy), 32'd0);
        // start held high with rd=0
        @(negedge clk);
        funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd4; rd_in = 5'd0; start = 1'b1;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held/first", n, 33);
        n = 0;
        seen = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (regwrite) seen = 1;
        end while (!done && n < 100);
        check("held/period", n, 34);
        check("held/result", result, 32'd12);
        check("held/noreg", seen + 32'(regwrite), 0);
        start = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
